// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide sequencer: FSM states, op codes
// and the iteration count.
package muldiv_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic OP_MUL       = 1'b0;
   localparam logic OP_DIV       = 1'b1;
   localparam int   MULDIV_ITERS = 32;
endpackage

// File: rtl/muldiv_iter_step.sv
// One combinational iteration: shift-add multiply step or restoring-divide
// trial-subtract step, selected by i_op.
module muldiv_iter_step
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MULDIV_ITERS
) (
   input  logic             i_op,
   input  logic [WIDTH-1:0] i_hi,
   input  logic [WIDTH-1:0] i_lo,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH-1:0] w_rem;
   logic             w_ge;

   always_comb begin
      w_sum   = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_b} : '0);
      w_shift = {i_hi, i_lo[WIDTH-1]};
      w_ge    = (w_shift >= {1'b0, i_b});
      // Remainder after a successful subtract is below the divisor, so it fits WIDTH bits.
      w_rem   = WIDTH'(w_shift - {1'b0, i_b});
      if (i_op == OP_MUL) begin
         o_hi = w_sum[WIDTH:1];
         o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
      end else if (w_ge) begin
         o_hi = w_rem;
         o_lo = {i_lo[WIDTH-2:0], 1'b1};
      end else begin
         o_hi = w_shift[WIDTH-1:0];
         o_lo = {i_lo[WIDTH-2:0], 1'b0};
      end
   end
endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULTU/DIVU controller holding HI/LO, with MTHI/MTLO writes.
// Define MULDIV_SIGNED_EN to add the op_signed port (signed ops, +1 cycle).
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MULDIV_ITERS,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op,
`ifdef MULDIV_SIGNED_EN
   input  logic             op_signed,
`endif
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             wr_hi,
   input  logic             wr_lo,
   input  logic [WIDTH-1:0] wr_data,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_op;
   logic [WIDTH-1:0]   r_acc_hi, r_acc_lo, r_b;
   logic [WIDTH-1:0]   r_hi, r_lo;
   logic               r_busy, r_done, r_div_zero;
   logic [WIDTH-1:0]   w_a_mag, w_b_mag;
   logic [WIDTH-1:0]   w_step_hi, w_step_lo;

`ifdef MULDIV_SIGNED_EN
   localparam logic [CNT_W-1:0] ITERS = CNT_W'(WIDTH);
   logic               r_sgn, r_neg_q, r_neg_r;
   logic               w_neg_a, w_neg_b;
   logic [2*WIDTH-1:0] w_prod_neg;
   logic [WIDTH-1:0]   w_fix_hi, w_fix_lo;

   assign w_neg_a    = op_signed & src_a[WIDTH-1];
   assign w_neg_b    = op_signed & src_b[WIDTH-1];
   assign w_a_mag    = w_neg_a ? -src_a : src_a;
   assign w_b_mag    = w_neg_b ? -src_b : src_b;
   assign w_prod_neg = -{r_acc_hi, r_acc_lo};

   always_comb begin
      if (r_op == OP_MUL) begin
         {w_fix_hi, w_fix_lo} = r_neg_q ? w_prod_neg : {r_acc_hi, r_acc_lo};
      end else begin
         w_fix_lo = r_neg_q ? -r_acc_lo : r_acc_lo;
         w_fix_hi = r_neg_r ? -r_acc_hi : r_acc_hi;
      end
   end
`else
   assign w_a_mag = src_a;
   assign w_b_mag = src_b;
`endif

   muldiv_iter_step #(.WIDTH(WIDTH)) u_step (
      .i_op (r_op),
      .i_hi (r_acc_hi),
      .i_lo (r_acc_lo),
      .i_b  (r_b),
      .o_hi (w_step_hi),
      .o_lo (w_step_lo)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_op       <= OP_MUL;
         r_acc_hi   <= '0;
         r_acc_lo   <= '0;
         r_b        <= '0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_div_zero <= 1'b0;
`ifdef MULDIV_SIGNED_EN
         r_sgn      <= 1'b0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
`endif
      end else begin
         r_done     <= 1'b0;
         r_div_zero <= 1'b0;
         case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  r_op  <= op;
                  r_cnt <= '0;
`ifdef MULDIV_SIGNED_EN
                  r_sgn   <= op_signed;
                  r_neg_q <= w_neg_a ^ w_neg_b;
                  r_neg_r <= w_neg_a;
`endif
                  if (op == OP_DIV && src_b == '0) begin
                     r_hi       <= src_a;
                     r_lo       <= '1;
                     r_done     <= 1'b1;
                     r_div_zero <= 1'b1;
                     r_state    <= DONE;
                  end else begin
                     // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
                     r_acc_hi <= '0;
                     r_acc_lo <= (op == OP_MUL) ? w_b_mag : w_a_mag;
                     r_b      <= (op == OP_MUL) ? w_a_mag : w_b_mag;
                     r_busy   <= 1'b1;
                     r_state  <= CALC;
                  end
               end else begin
                  if (wr_hi) r_hi <= wr_data;
                  if (wr_lo) r_lo <= wr_data;
                  r_state <= IDLE;
               end
            end
            CALC: begin
               r_acc_hi <= w_step_hi;
               r_acc_lo <= w_step_lo;
               r_cnt    <= r_cnt + CNT_W'(1);
`ifdef MULDIV_SIGNED_EN
               if (r_sgn && r_cnt == ITERS) begin
                  r_hi    <= w_fix_hi;
                  r_lo    <= w_fix_lo;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end else if (!r_sgn && r_cnt == LAST) begin
`else
               if (r_cnt == LAST) begin
`endif
                  r_hi    <= w_step_hi;
                  r_lo    <= w_step_lo;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign div_zero = r_div_zero;
   assign hi       = r_hi;
   assign lo       = r_lo;
endmodule
